// File: rtl/stopwatch_core_100hz_if.sv
// Signal bundle between the stopwatch core and its surroundings:
// divided tick and raw buttons in, status flags and BCD display digits out.
interface stopwatch_core_100hz_if;
  logic       tick_in;
  logic       btn_start_stop;
  logic       btn_lap;
  logic       btn_clear;
  logic       tick_pulse;
  logic       running;
  logic       lap_active;
  logic       overflow;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [3:0] cs_tens;
  logic [3:0] cs_ones;

  modport master (
    output tick_in, btn_start_stop, btn_lap, btn_clear,
    input  tick_pulse, running, lap_active, overflow,
    input  min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones
  );

  modport slave (
    input  tick_in, btn_start_stop, btn_lap, btn_clear,
    output tick_pulse, running, lap_active, overflow,
    output min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones
  );
endinterface

// File: rtl/stopwatch_core_100hz.sv
// Centisecond stopwatch: 100 Hz edge-to-tick conversion, tick-rate button
// debounce, IDLE/RUN/PAUSE control with lap snapshot, saturating MM:SS.CC count.
module stopwatch_core_100hz #(
  parameter int unsigned DEBOUNCE_SAMPLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  stopwatch_core_100hz_if.slave  sw
);
  localparam int unsigned CNT_W   = 4;
  localparam int          NBTN    = 3;
  localparam int          B_START = 0;
  localparam int          B_LAP   = 1;
  localparam int          B_CLEAR = 2;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] cs_tens;
    logic [3:0] cs_ones;
  } bcd_time_t;

  localparam bcd_time_t MAX_TIME = 24'h595999;

  logic                       tick_in_d;
  logic                       tick_pulse_q;
  logic [NBTN-1:0]            btn_raw_c;
  logic [NBTN-1:0]            sync1_q, sync2_q;
  logic [NBTN-1:0]            deb_q, deb_d;
  logic [NBTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NBTN-1:0]            press_c;
  state_t                     state_q, state_d;
  bcd_time_t                  count_q, count_d;
  bcd_time_t                  snap_q, snap_d;
  bcd_time_t                  disp_q;
  logic                       lap_q, lap_d;
  logic                       ovf_q, ovf_d;
  logic                       running_q;

  assign btn_raw_c = {sw.btn_clear, sw.btn_lap, sw.btn_start_stop};

  // Next legal BCD value; caller guarantees the input is below MAX_TIME.
  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.cs_ones != 4'd9) begin
      r.cs_ones = t.cs_ones + 4'd1;
    end else begin
      r.cs_ones = 4'd0;
      if (t.cs_tens != 4'd9) begin
        r.cs_tens = t.cs_tens + 4'd1;
      end else begin
        r.cs_tens = 4'd0;
        if (t.sec_ones != 4'd9) begin
          r.sec_ones = t.sec_ones + 4'd1;
        end else begin
          r.sec_ones = 4'd0;
          if (t.sec_tens != 4'd5) begin
            r.sec_tens = t.sec_tens + 4'd1;
          end else begin
            r.sec_tens = 4'd0;
            if (t.min_ones != 4'd9) begin
              r.min_ones = t.min_ones + 4'd1;
            end else begin
              r.min_ones = 4'd0;
              r.min_tens = t.min_tens + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  // Per-button debounce evaluated only on ticks; press is the 0->1 flip.
  always_comb begin
    logic [CNT_W-1:0] cnt_inc;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    press_c = '0;
    cnt_inc = '0;
    if (tick_pulse_q) begin
      for (int i = 0; i < NBTN; i++) begin
        cnt_inc = cnt_q[i] + CNT_W'(1);
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_inc == CNT_W'(DEBOUNCE_SAMPLES)) begin
            deb_d[i]   = sync2_q[i];
            cnt_d[i]   = '0;
            press_c[i] = sync2_q[i];
          end else begin
            cnt_d[i] = cnt_inc;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Control FSM and count update; only the top legal event per tick acts.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    snap_d  = snap_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;
    if (tick_pulse_q) begin
      case (state_q)
        IDLE: begin
          if (press_c[B_START]) state_d = RUN;
        end
        RUN: begin
          if (press_c[B_START]) begin
            state_d = PAUSE;
          end else begin
            if (press_c[B_LAP]) begin
              lap_d = ~lap_q;
              if (!lap_q) snap_d = count_q;
            end
            if (count_q == MAX_TIME) begin
              ovf_d   = 1'b1;
              state_d = PAUSE;
            end else begin
              count_d = bcd_inc(count_q);
            end
          end
        end
        PAUSE: begin
          if (press_c[B_CLEAR]) begin
            state_d = IDLE;
            count_d = '0;
            snap_d  = '0;
            lap_d   = 1'b0;
            ovf_d   = 1'b0;
          end else if (press_c[B_START]) begin
            state_d = RUN;
          end else if (press_c[B_LAP] && lap_q) begin
            lap_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Edge detect, synchronisers, debounce state, count and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_in_d    <= 1'b1;
      tick_pulse_q <= 1'b0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      cnt_q        <= '0;
      count_q      <= '0;
      snap_q       <= '0;
      lap_q        <= 1'b0;
      ovf_q        <= 1'b0;
      disp_q       <= '0;
      running_q    <= 1'b0;
    end else begin
      tick_in_d    <= sw.tick_in;
      tick_pulse_q <= sw.tick_in & ~tick_in_d;
      sync1_q      <= btn_raw_c;
      sync2_q      <= sync1_q;
      deb_q        <= deb_d;
      cnt_q        <= cnt_d;
      count_q      <= count_d;
      snap_q       <= snap_d;
      lap_q        <= lap_d;
      ovf_q        <= ovf_d;
      disp_q       <= lap_d ? snap_d : count_d;
      running_q    <= (state_d == RUN);
    end
  end

  assign sw.tick_pulse = tick_pulse_q;
  assign sw.running    = running_q;
  assign sw.lap_active = lap_q;
  assign sw.overflow   = ovf_q;
  assign sw.min_tens   = disp_q.min_tens;
  assign sw.min_ones   = disp_q.min_ones;
  assign sw.sec_tens   = disp_q.sec_tens;
  assign sw.sec_ones   = disp_q.sec_ones;
  assign sw.cs_tens    = disp_q.cs_tens;
  assign sw.cs_ones    = disp_q.cs_ones;
endmodule
